// File: rtl/ysyx_22040237_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040237_seq_if
// Description : Instruction-memory fetch channel between the sequencer and
//               the instruction memory. The request half uses a valid/ready
//               handshake. The response half is valid-only, so the memory
//               must hold the data until the sequencer samples it.
//   imem_req_valid : fetch request valid          (sequencer -> memory)
//   imem_req_addr  : fetch address                (sequencer -> memory)
//   imem_req_ready : memory accepts the request   (memory -> sequencer)
//   imem_rsp_valid : response data valid          (memory -> sequencer)
//   imem_rsp_data  : fetched instruction word     (memory -> sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22040237_seq_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040237_seq.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040237_seq
// Description : Multi-cycle sequencer. It owns the PC and fetches over the
//               imem channel. It steps each instruction through the
//               sequence DECODE -> EXEC -> WB, and gates the EX stage and the
//               register-file write.
//               It halts on ebreak. It raises a sticky error on a fetch
//               timeout or on a misaligned jump target.
//               It keeps 64-bit cycle and retired-instruction counters.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               imem            - fetch channel (master side)
//               pc, inst        - in-flight PC and latched instruction
//               inst_ebreak     - decoder ebreak flag (sampled in DECODE)
//               jump_en/target  - EXU next-PC override (sampled in EXEC)
//               ex_en, wb_en    - EX capture strobe, regfile write qualifier
//               halt, err       - sticky terminal status
//               cycle_cnt       - cycle counter
//               instret_cnt     - retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040237_seq #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    ysyx_22040237_seq_if.master       imem,
    output logic [31:0]               pc,
    output logic [31:0]               inst,
    input  wire logic                 inst_ebreak,
    input  wire logic                 jump_en,
    input  wire logic [31:0]          jump_target,
    output logic                      ex_en,
    output logic                      wb_en,
    output logic                      halt,
    output logic                      err,
    output logic [63:0]               cycle_cnt,
    output logic [63:0]               instret_cnt
);

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [15:0] TIMEOUT_LIM = 16'(FETCH_TIMEOUT);

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        EXEC       = 3'd3,
        WB         = 3'd4,
        HALT       = 3'd5,
        ERR        = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] npc;
    logic [15:0] to_cnt;
    logic [15:0] to_cnt_inc;
    logic        bad_target;

    // The counter holds the number of completed empty wait cycles. Reaching
    // the limit on the incremented value makes the error edge the one that
    // ends the FETCH_TIMEOUT-th empty cycle.
    assign to_cnt_inc = to_cnt + 16'd1;
    assign bad_target = jump_en && (jump_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_REQ: begin
                if (imem.imem_req_ready) begin
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                // A response in the final allowed cycle takes priority over the timeout.
                if (imem.imem_rsp_valid) begin
                    state_nxt = DECODE;
                end else if (to_cnt_inc == TIMEOUT_LIM) begin
                    state_nxt = ERR;
                end
            end
            DECODE:  state_nxt = inst_ebreak ? HALT : EXEC;
            EXEC:    state_nxt = bad_target ? ERR : WB;
            WB:      state_nxt = FETCH_REQ;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inst        <= NOP_INST;
            npc         <= RESET_PC;
            to_cnt      <= 16'd0;
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            if (state != HALT && state != ERR) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            case (state)
                FETCH_REQ: begin
                    if (imem.imem_req_ready) begin
                        to_cnt <= 16'd0;
                    end
                end
                FETCH_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        inst <= imem.imem_rsp_data;
                    end else begin
                        to_cnt <= to_cnt_inc;
                    end
                end
                DECODE: begin
                    // ebreak retires here because it never reaches WB.
                    if (inst_ebreak) begin
                        instret_cnt <= instret_cnt + 64'd1;
                    end
                end
                EXEC: begin
                    npc <= jump_en ? jump_target : pc + 32'd4;
                end
                WB: begin
                    pc          <= npc;
                    instret_cnt <= instret_cnt + 64'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // All strobes and status flags decode from the state register only.
    assign imem.imem_req_valid = (state == FETCH_REQ);
    assign imem.imem_req_addr  = pc;
    assign ex_en               = (state == EXEC);
    assign wb_en               = (state == WB);
    assign halt                = (state == HALT);
    assign err                 = (state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040237_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040237_seq
// Description : Self-checking bench for ysyx_22040237_seq. The stimulus
//               drives directed fetch transactions and queues the expected
//               request addresses and write-back records. A monitor process
//               compares these against the DUT outputs.
//               A second instance with RESET_PC=FFFF_FFFC covers PC
//               wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040237_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22040237_seq_if bus ();
    ysyx_22040237_seq_if wbus ();

    logic [31:0] pc, inst, jump_target;
    logic        inst_ebreak, jump_en, ex_en, wb_en, halt, err;
    logic [63:0] cycle_cnt, instret_cnt;

    logic [31:0] w_pc, w_inst;
    logic        w_ex_en, w_wb_en, w_halt, w_err;
    logic [63:0] w_cycle_cnt, w_instret_cnt;

    ysyx_22040237_seq #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .imem(bus.master),
        .pc(pc), .inst(inst), .inst_ebreak(inst_ebreak),
        .jump_en(jump_en), .jump_target(jump_target),
        .ex_en(ex_en), .wb_en(wb_en), .halt(halt), .err(err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    ysyx_22040237_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .imem(wbus.master),
        .pc(w_pc), .inst(w_inst), .inst_ebreak(1'b0),
        .jump_en(1'b0), .jump_target(32'h0),
        .ex_en(w_ex_en), .wb_en(w_wb_en), .halt(w_halt), .err(w_err),
        .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] cyc;
    } wb_t;

    logic [31:0] addr_q[$];
    wb_t         wb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        inst_ebreak = 1'b0;
        jump_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Run one instruction from the FETCH_REQ cycle. Leaves the DUT one
    // cycle past WB, or past DECODE/EXEC when it halts or errors there.
    task automatic do_instr(input logic [31:0] addr, input logic [31:0] data,
                            input int rdy_dly, input int rsp_dly,
                            input logic ebrk, input logic jen, input logic [31:0] jtgt,
                            input logic exp_wb, input logic [63:0] wb_cyc);
        wb_t e;
        addr_q.push_back(addr);
        if (exp_wb) begin
            e.pc = addr; e.inst = data; e.cyc = wb_cyc;
            wb_q.push_back(e);
        end
        bus.imem_req_ready = 1'b0;
        repeat (rdy_dly) tick();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        repeat (rsp_dly) tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
        inst_ebreak = ebrk;
        tick();
        inst_ebreak = 1'b0;
        if (!ebrk) begin
            jump_en = jen;
            jump_target = jtgt;
            tick();
            jump_en = 1'b0;
            if (exp_wb) tick();
        end
    endtask

    // Monitor: checks request addresses while valid and pops on handshake,
    // and checks every write-back against the scoreboard.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.imem_req_valid) begin
                    if (addr_q.size() > 0) begin
                        check("req_addr", {32'h0, bus.imem_req_addr}, {32'h0, addr_q[0]});
                        if (bus.imem_req_ready) void'(addr_q.pop_front());
                    end else if (bus.imem_req_ready) begin
                        check("unexpected_req", {63'h0, bus.imem_req_valid}, 64'h0);
                    end
                end
                if (wb_en) begin
                    check("ex_wb_overlap", {63'h0, ex_en}, 64'h0);
                    if (wb_q.size() == 0) begin
                        check("unexpected_wb", {63'h0, wb_en}, 64'h0);
                    end else begin
                        e = wb_q.pop_front();
                        check("wb_pc", {32'h0, pc}, {32'h0, e.pc});
                        check("wb_inst", {32'h0, inst}, {32'h0, e.inst});
                        check("wb_cycle", cycle_cnt, e.cyc);
                    end
                end
                if (halt && err) check("halt_err_overlap", 64'h1, 64'h0);
            end
        end
    end

    initial begin
        int req_seen;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        wbus.imem_req_ready = 1'b0;
        wbus.imem_rsp_valid = 1'b0;
        wbus.imem_rsp_data  = 32'h0;
        inst_ebreak = 1'b0;
        jump_en = 1'b0;
        jump_target = 32'h0;

        // Reset values
        do_reset();
        check("rst_pc", {32'h0, pc}, {32'h0, RST_PC});
        check("rst_inst", {32'h0, inst}, {32'h0, NOP});
        check("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        check("rst_req_addr", {32'h0, bus.imem_req_addr}, {32'h0, RST_PC});
        check("rst_flags", {60'h0, ex_en, wb_en, halt, err}, 64'h0);
        check("rst_cycle", cycle_cnt, 64'h0);
        check("rst_instret", instret_cnt, 64'h0);

        // Straight-line: three addi, write-backs at cycles 4, 9, 14
        do_instr(32'h8000_0000, 32'h0010_0093, 0, 0, 0, 0, 0, 1, 64'd4);
        do_instr(32'h8000_0004, 32'h0020_0113, 0, 0, 0, 0, 0, 1, 64'd9);
        do_instr(32'h8000_0008, 32'h0030_0193, 0, 0, 0, 0, 0, 1, 64'd14);
        check("line_pc", {32'h0, pc}, 64'h8000_000C);
        check("line_instret", instret_cnt, 64'd3);

        // Backpressure: ready low 3 cycles, response 2 cycles late -> 10 cycles
        do_instr(32'h8000_000C, 32'h0040_0213, 3, 2, 0, 0, 0, 1, 64'd24);
        check("bp_cycle", cycle_cnt, 64'd25);

        // Aligned jump, then misaligned jump
        do_instr(32'h8000_0010, 32'h0F00_006F, 0, 0, 0, 1, 32'h8000_0100, 1, 64'd29);
        check("jmp_pc", {32'h0, pc}, 64'h8000_0100);
        do_instr(32'h8000_0100, 32'h0020_006F, 0, 0, 0, 1, 32'h8000_0102, 0, 64'd0);
        check("mis_err", {62'h0, halt, err}, 64'h1);
        check("mis_pc", {32'h0, pc}, 64'h8000_0100);
        check("mis_instret", instret_cnt, 64'd5);
        check("mis_cycle", cycle_cnt, 64'd34);
        repeat (3) tick();
        check("mis_cycle_frozen", cycle_cnt, 64'd34);

        // ebreak
        do_reset();
        do_instr(RST_PC, 32'h0010_0073, 0, 0, 1, 0, 0, 0, 64'd0);
        check("ebrk_halt", {62'h0, halt, err}, 64'h2);
        check("ebrk_instret", instret_cnt, 64'd1);
        check("ebrk_cycle", cycle_cnt, 64'd3);
        bus.imem_req_ready = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.imem_req_valid || wb_en || ex_en) req_seen++;
        end
        bus.imem_req_ready = 1'b0;
        check("ebrk_quiet", 64'(req_seen), 64'd0);
        check("ebrk_cycle_frozen", cycle_cnt, 64'd3);
        check("ebrk_instret_frozen", instret_cnt, 64'd1);

        // Response in the 4th wait cycle wins over the timeout
        do_reset();
        do_instr(RST_PC, 32'h0010_0093, 0, 3, 0, 0, 0, 1, 64'd7);
        check("late_rsp_err", {63'h0, err}, 64'h0);
        check("late_rsp_instret", instret_cnt, 64'd1);

        // Reset during FETCH_WAIT with a simultaneous response
        addr_q.push_back(32'h8000_0004);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        check("mid_rst_inst", {32'h0, inst}, {32'h0, NOP});
        check("mid_rst_pc", {32'h0, pc}, {32'h0, RST_PC});
        check("mid_rst_req", {63'h0, bus.imem_req_valid}, 64'h1);
        check("mid_rst_cycle", cycle_cnt, 64'h0);
        check("mid_rst_instret", instret_cnt, 64'h0);
        // Response while in FETCH_REQ is ignored
        tick();
        bus.imem_rsp_valid = 1'b0;
        check("ignored_rsp_inst", {32'h0, inst}, {32'h0, NOP});

        // Timeout: no response, error after exactly 4 wait cycles
        do_reset();
        addr_q.push_back(RST_PC);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        repeat (3) tick();
        check("to_err_early", {63'h0, err}, 64'h0);
        tick();
        check("to_err", {63'h0, err}, 64'h1);
        check("to_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        check("to_cycle", cycle_cnt, 64'd5);

        // PC wrap on the second instance
        wbus.imem_req_ready = 1'b1;
        tick();
        wbus.imem_req_ready = 1'b0;
        wbus.imem_rsp_valid = 1'b1;
        wbus.imem_rsp_data  = NOP;
        tick();
        wbus.imem_rsp_valid = 1'b0;
        tick();
        check("wrap_ex_en", {63'h0, w_ex_en}, 64'h1);
        tick();
        check("wrap_wb_pc", {31'h0, w_wb_en, w_pc}, 64'h1_FFFF_FFFC);
        tick();
        check("wrap_req", {31'h0, wbus.imem_req_valid, wbus.imem_req_addr}, 64'h1_0000_0000);
        check("wrap_pc", {32'h0, w_pc}, 64'h0);

        repeat (2) tick();
        if (addr_q.size() != 0 || wb_q.size() != 0)
            check("queues_drained", 64'(addr_q.size() + wb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
